// File: rtl/set_fsm.sv
// Settable 24-hour clock core: button-driven digit editing in set mode,
// prescaled seconds counting with full carry in run mode.
module set_fsm #(
  parameter int CLKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nextbutton,
  input  logic       button1,
  input  logic       button2,
  input  logic       isset,
  output logic [1:0] hour1,
  output logic [3:0] hour2,
  output logic [3:0] min1,
  output logic [3:0] min2,
  output logic [3:0] sec1,
  output logic [3:0] sec2
);

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);

  typedef enum logic [1:0] {SEL_HOUR, SEL_MIN, SEL_SEC} sel_t;

  sel_t          r_sel, w_sel_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_nb_hist, r_b1_hist, r_b2_hist;
  logic [1:0]    r_hour1, w_hour1_nxt;
  logic [3:0]    r_hour2, w_hour2_nxt;
  logic [3:0]    r_min1, w_min1_nxt;
  logic [3:0]    r_min2, w_min2_nxt;
  logic [3:0]    r_sec1, w_sec1_nxt;
  logic [3:0]    r_sec2, w_sec2_nxt;
  logic          w_nb_press, w_b1_press, w_b2_press;
  logic          w_tick;

  function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] last);
    return (d >= last) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [1:0] hour_tens_inc(input logic [1:0] h);
    return (h >= 2'd2) ? 2'd0 : h + 2'd1;
  endfunction

  assign w_nb_press = nextbutton & ~r_nb_hist;
  assign w_b1_press = button1    & ~r_b1_hist;
  assign w_b2_press = button2    & ~r_b2_hist;

  assign w_tick      = isset && (r_presc == PRESC_LAST);
  assign w_presc_nxt = (!isset || w_tick) ? '0 : r_presc + PW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sel <= SEL_HOUR;
    end else begin
      r_sel <= w_sel_nxt;
    end
  end

  always_comb begin
    w_sel_nxt = r_sel;
    if (isset) begin
      w_sel_nxt = SEL_HOUR;
    end else if (w_nb_press) begin
      case (r_sel)
        SEL_HOUR: w_sel_nxt = SEL_MIN;
        SEL_MIN:  w_sel_nxt = SEL_SEC;
        default:  w_sel_nxt = SEL_HOUR;
      endcase
    end
  end

  always_comb begin
    w_hour1_nxt = r_hour1;
    w_hour2_nxt = r_hour2;
    w_min1_nxt  = r_min1;
    w_min2_nxt  = r_min2;
    w_sec1_nxt  = r_sec1;
    w_sec2_nxt  = r_sec2;
    if (isset) begin
      // Ripple carry: each field only moves when every lower field wraps.
      if (w_tick) begin
        w_sec2_nxt = wrap_inc(r_sec2, 4'd9);
        if (r_sec2 >= 4'd9) begin
          w_sec1_nxt = wrap_inc(r_sec1, 4'd5);
          if (r_sec1 >= 4'd5) begin
            w_min2_nxt = wrap_inc(r_min2, 4'd9);
            if (r_min2 >= 4'd9) begin
              w_min1_nxt = wrap_inc(r_min1, 4'd5);
              if (r_min1 >= 4'd5) begin
                if (r_hour1 == 2'd2 && r_hour2 >= 4'd3) begin
                  w_hour1_nxt = 2'd0;
                  w_hour2_nxt = 4'd0;
                end else if (r_hour2 >= 4'd9) begin
                  w_hour1_nxt = hour_tens_inc(r_hour1);
                  w_hour2_nxt = 4'd0;
                end else begin
                  w_hour2_nxt = r_hour2 + 4'd1;
                end
              end
            end
          end
        end
      end
    end else begin
      case (r_sel)
        SEL_HOUR: begin
          if (w_b1_press) w_hour1_nxt = hour_tens_inc(r_hour1);
          if (w_b2_press) w_hour2_nxt = wrap_inc(r_hour2, (r_hour1 == 2'd2) ? 4'd3 : 4'd9);
          // Tens moving to 2 may leave an out-of-range units digit behind.
          if (w_hour1_nxt == 2'd2 && w_hour2_nxt > 4'd3) w_hour2_nxt = 4'd3;
        end
        SEL_MIN: begin
          if (w_b1_press) w_min1_nxt = wrap_inc(r_min1, 4'd5);
          if (w_b2_press) w_min2_nxt = wrap_inc(r_min2, 4'd9);
        end
        SEL_SEC: begin
          if (w_b1_press) w_sec1_nxt = wrap_inc(r_sec1, 4'd5);
          if (w_b2_press) w_sec2_nxt = wrap_inc(r_sec2, 4'd9);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_presc   <= '0;
      r_nb_hist <= 1'b0;
      r_b1_hist <= 1'b0;
      r_b2_hist <= 1'b0;
      r_hour1   <= 2'd0;
      r_hour2   <= 4'd0;
      r_min1    <= 4'd0;
      r_min2    <= 4'd0;
      r_sec1    <= 4'd0;
      r_sec2    <= 4'd0;
    end else begin
      r_presc   <= w_presc_nxt;
      r_nb_hist <= nextbutton;
      r_b1_hist <= button1;
      r_b2_hist <= button2;
      r_hour1   <= w_hour1_nxt;
      r_hour2   <= w_hour2_nxt;
      r_min1    <= w_min1_nxt;
      r_min2    <= w_min2_nxt;
      r_sec1    <= w_sec1_nxt;
      r_sec2    <= w_sec2_nxt;
    end
  end

  assign hour1 = r_hour1;
  assign hour2 = r_hour2;
  assign min1  = r_min1;
  assign min2  = r_min2;
  assign sec1  = r_sec1;
  assign sec2  = r_sec2;

endmodule

// File: tb/tb_set_fsm.sv
// Directed bench for set_fsm; time is compared as a packed BCD word hh_mm_ss.
module tb_set_fsm;

  localparam int CPS = 4;
  localparam int NB = 0, B1 = 1, B2 = 2;

  logic       clk = 1'b0;
  logic       reset, nextbutton, button1, button2, isset;
  logic [1:0] hour1;
  logic [3:0] hour2, min1, min2, sec1, sec2;

  int n_vec = 0;
  int n_err = 0;

  set_fsm #(.CLKS_PER_SEC(CPS)) dut (
    .clk(clk), .reset(reset), .nextbutton(nextbutton),
    .button1(button1), .button2(button2), .isset(isset),
    .hour1(hour1), .hour2(hour2), .min1(min1), .min2(min2),
    .sec1(sec1), .sec2(sec2)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] cur_time();
    return {2'b00, hour1, hour2, min1, min2, sec1, sec2};
  endfunction

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      NB:      nextbutton = 1'b1;
      B1:      button1    = 1'b1;
      default: button2    = 1'b1;
    endcase
    cyc(1);
    nextbutton = 1'b0;
    button1    = 1'b0;
    button2    = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_n(input int which, input int n);
    repeat (n) pulse(which);
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; nextbutton = 1'b0; button1 = 1'b0; button2 = 1'b0; isset = 1'b0;
    cyc(10);
    chk("reset", cur_time(), 24'h000000);
    reset = 1'b1;
    cyc(5);
    chk("idle", cur_time(), 24'h000000);

    pulse(B1);
    chk("hr_tens", cur_time(), 24'h100000);
    pulse_n(B2, 2);
    chk("hr_units", cur_time(), 24'h120000);
    pulse(NB);
    pulse_n(B2, 3);
    chk("min_units", cur_time(), 24'h120300);
    pulse_n(NB, 2);
    chk("sel_wrap", cur_time(), 24'h120300);
    pulse(B2);
    chk("sel_hour", cur_time(), 24'h130300);

    rst_pulse();
    pulse(B1);
    pulse_n(B2, 9);
    chk("preset19", cur_time(), 24'h190000);
    pulse(B1);
    chk("hr_clamp", cur_time(), 24'h230000);
    pulse(B2);
    chk("hr_u_wrap3", cur_time(), 24'h200000);
    pulse(B1);
    chk("hr_t_wrap", cur_time(), 24'h000000);
    pulse(NB);
    pulse_n(B1, 5);
    chk("min_t5", cur_time(), 24'h005000);
    pulse(B1);
    chk("min_t_wrap", cur_time(), 24'h000000);

    button2 = 1'b1;
    cyc(1);
    chk("hold_first", cur_time(), 24'h000100);
    cyc(19);
    button2 = 1'b0;
    cyc(2);
    chk("hold_once", cur_time(), 24'h000100);
    pulse_n(B2, 9);
    chk("min_u_wrap", cur_time(), 24'h000000);

    rst_pulse();
    pulse_n(B1, 2);
    pulse_n(B2, 3);
    pulse(NB);
    pulse_n(B1, 5);
    pulse_n(B2, 9);
    pulse(NB);
    pulse_n(B1, 5);
    pulse_n(B2, 8);
    chk("preset_run", cur_time(), 24'h235958);

    isset = 1'b1;
    cyc(3);
    chk("run_pre", cur_time(), 24'h235958);
    cyc(1);
    chk("run_tick1", cur_time(), 24'h235959);
    cyc(4);
    chk("run_daywrap", cur_time(), 24'h000000);
    pulse(B1);
    chk("run_b1", cur_time(), 24'h000000);
    pulse(B2);
    chk("run_b2", cur_time(), 24'h000001);
    pulse(NB);
    pulse(B2);
    chk("run_nb", cur_time(), 24'h000002);

    cyc(2);
    rst_pulse();
    chk("rst_run", cur_time(), 24'h000000);
    cyc(3);
    chk("rst_presc", cur_time(), 24'h000000);
    cyc(1);
    chk("rst_tick", cur_time(), 24'h000001);

    isset = 1'b0;
    cyc(10);
    chk("freeze", cur_time(), 24'h000001);
    isset = 1'b1;
    cyc(3);
    chk("resume_pre", cur_time(), 24'h000001);
    cyc(1);
    chk("resume_tick", cur_time(), 24'h000002);

    isset = 1'b0;
    button2 = 1'b1;
    reset = 1'b0;
    cyc(1);
    chk("rst_held", cur_time(), 24'h000000);
    reset = 1'b1;
    cyc(1);
    chk("held_release", cur_time(), 24'h010000);
    cyc(5);
    button2 = 1'b0;
    cyc(2);
    chk("held_once", cur_time(), 24'h010000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/set_fsm.md
Name: set_fsm

Overview:
Settable 24-hour digital clock core. In set mode, three push-buttons edit the hour, minute and second fields digit by digit. In run mode, a prescaler-driven seconds counter advances the time with full carry. It drives six BCD digit outputs to the display/decoder stage.

Parameters:
CLKS_PER_SEC, 100000000, clk cycles per one-second tick in run mode; benches override with a small value such as 4.

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-low reset
nextbutton  input  1  advance the selected field (set mode)
button1  input  1  increment the tens digit of the selected field (set mode)
button2  input  1  increment the units digit of the selected field (set mode)
isset  input  1  0 = set mode (editing), 1 = run mode (time counts)
hour1  output  2  hours tens, 0..2
hour2  output  4  hours units, 0..9 (0..3 when hour1=2)
min1  output  4  minutes tens, 0..5
min2  output  4  minutes units, 0..9
sec1  output  4  seconds tens, 0..5
sec2  output  4  seconds units, 0..9

Behaviour:
- One clock domain. Reset is synchronous and active-low. On a clk edge with reset=0:
  - all six digits = 0 (00:00:00)
  - field selector = HOUR
  - prescaler = 0
  - button history registers = 0
- All outputs are registered and come directly from the digit registers.
- Button edge detection:
  - Each button has a history flop.
  - A press is input=1 while history=0.
  - Each press acts exactly once, however long it is held. One-cycle pulses are valid presses.
  - The digit or field update commits on the same clk edge that first samples the input high, so outputs change one edge after the press is seen.
  - A button already high when reset releases counts as one press.
- Field selector states: HOUR -> MIN -> SEC -> HOUR, one step per nextbutton press, set mode only.
- Set mode (isset=0):
  - Prescaler is held at 0.
  - button1 press increments the selected field's tens digit:
    - hour tens wraps 0,1,2,0
    - min/sec tens wrap 0..5,0
  - button2 press increments the selected field's units digit, with no carry into tens:
    - wraps 9 -> 0
    - hour units wraps 3 -> 0 when hour1=2
  - Hour tens becoming 2 while hour units >3 clamps hour units to 3.
  - button1 and button2 in the same cycle: both apply to the same field, then the hour clamp applies.
  - A digit press and nextbutton in the same cycle: the digit press applies to the current field, then the selector advances.
- Run mode (isset=1):
  - Selector is forced to HOUR. All buttons are ignored, but their history flops keep tracking the inputs.
  - Prescaler counts 0..CLKS_PER_SEC-1. On the terminal count it wraps to 0 and issues a one-cycle tick.
  - On a tick, seconds increment with full carry:
    - sec 59 -> 00 with minute+1
    - min 59 -> 00 with hour+1
    - 23:59:59 -> 00:00:00
- Mode changes:
  - Entering set mode freezes the time at its current value.
  - Returning to run mode restarts the prescaler from 0, so the first tick comes CLKS_PER_SEC cycles later.
- Reset mid-operation, in either mode, takes priority over all other actions on that edge.
- Illegal digit values cannot occur. Every write wraps or clamps within the ranges above.

Test Plan:
- Reset: hold reset=0 for 10 cycles, then release -> 00:00:00 and selector=HOUR; no output change without stimulus in set mode.
- Hour setting, isset=0: one 1-cycle button1 pulse and two 1-cycle button2 pulses -> 12:00:00. Then nextbutton, then three button2 pulses -> 12:03:00. Then nextbutton twice -> selector back to HOUR, time unchanged.
- Wrap/clamp: set 19:00:00, press button1 -> 29 is clamped to 23:00:00. Press button2 -> 20:00:00. Press button1 -> 00:00:00. Min tens pressed 6 times returns to 0.
- Held button: button2 held high 20 cycles on MIN -> minutes units increments by exactly 1.
- Run carry, CLKS_PER_SEC=4: preset 23:59:58, set isset=1 -> 23:59:59 after 4 cycles, 00:00:00 after 8. Button pulses during run mode cause no change.
- Reset mid-run: assert reset=0 for one edge while counting -> 00:00:00 on that edge; prescaler restarts.
